// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl_pkg
// Brief    : Shared funct3 codes, FSM state encoding and access-size helpers
//            for the load/store unit.
// Revision : 1.0  initial release
// ============================================================================
package lsu_ctrl_pkg;

    // RV32I load/store funct3 codes
    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LW  = 3'd2;
    localparam logic [2:0] LSU_LBU = 3'd4;
    localparam logic [2:0] LSU_LHU = 3'd5;
    localparam logic [2:0] LSU_SB  = 3'd0;
    localparam logic [2:0] LSU_SH  = 3'd1;
    localparam logic [2:0] LSU_SW  = 3'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_ACC0 = 2'd1,
        LSU_ACC1 = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // Access size in bytes from funct3[1:0] (3 is illegal and never reaches RAM)
    function automatic logic [2:0] lsu_size(input logic [1:0] sz);
        case (sz)
            2'd0:    lsu_size = 3'd1;
            2'd1:    lsu_size = 3'd2;
            default: lsu_size = 3'd4;
        endcase
    endfunction

    // An access crosses a word boundary when its last byte lies in the next word
    function automatic logic lsu_crosses(input logic [1:0] off, input logic [2:0] funct3);
        logic [2:0] w_end;
        w_end = {1'b0, off} + lsu_size(funct3[1:0]);
        lsu_crosses = (w_end > 3'd4);
    endfunction

    function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            lsu_illegal = (funct3 > LSU_SW);
        else
            lsu_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl_align
// Brief    : Purely combinational lane logic for the load/store unit.
//            i_off/i_funct3 : byte offset and access type
//            i_wdata        : LSB-aligned store data
//            i_rd_lo/i_rd_hi: first/second RAM word of a load
//            o_mask         : 8-bit byte mask over the two-word window
//            o_wshift       : store data placed into the two-word window
//            o_load         : extracted, sign/zero-extended load word
//            o_cross        : access spans two words
// Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl_align (
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rd_lo,
    input  logic [31:0] i_rd_hi,
    output logic [7:0]  o_mask,
    output logic [63:0] o_wshift,
    output logic [31:0] o_load,
    output logic        o_cross
);
    import lsu_ctrl_pkg::*;

    logic [7:0]  w_size_mask;
    logic [63:0] w_rshift;
    logic        w_sext;

    always_comb begin
        case (i_funct3[1:0])
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            default: w_size_mask = 8'h0F;
        endcase

        o_mask   = w_size_mask << i_off;
        o_wshift = {32'd0, i_wdata} << {i_off, 3'b000};
        w_rshift = {i_rd_hi, i_rd_lo} >> {i_off, 3'b000};

        // funct3[2] set selects the unsigned (BU/HU) variants
        w_sext = ~i_funct3[2];
        case (i_funct3[1:0])
            2'd0:    o_load = {{24{w_sext & w_rshift[7]}},  w_rshift[7:0]};
            2'd1:    o_load = {{16{w_sext & w_rshift[15]}}, w_rshift[15:0]};
            default: o_load = w_rshift[31:0];
        endcase

        o_cross = lsu_crosses(i_off, i_funct3);
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store unit between execute stage and a word-wide data RAM
//            (combinational read, posedge write, no byte enables). Sub-word
//            stores are read-modify-write; word-crossing accesses are split
//            into two word accesses (or flagged when MISALIGN_EN=0).
// Ports    : clk/rst                 clock, synchronous active-high reset
//            req_*                   request handshake and payload
//            rsp_valid_o/rdata/err   one-cycle response
//            ram_addr_o/wr_data/wr_en/ram_rd_data_i  data RAM word port
// Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wr_data_o,
    output logic              ram_wr_en_o,
    input  logic [DATA_W-1:0] ram_rd_data_i
);
    import lsu_ctrl_pkg::*;

    localparam logic [ADDR_W-3:0] c_word_inc = {{(ADDR_W-3){1'b0}}, 1'b1};

    lsu_state_t        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;
    logic              r_err;

    logic [7:0]        w_mask;
    logic [63:0]       w_wshift;
    logic [31:0]       w_load;
    logic              w_cross;
    logic [ADDR_W-1:0] w_word0;
    logic [ADDR_W-1:0] w_word1;
    logic [3:0]        w_lane_mask;
    logic [31:0]       w_lane_new;
    logic              w_bad_req;

    lsu_ctrl_align u_align (
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .i_wdata  (r_wdata),
        .i_rd_lo  (r_lo),
        .i_rd_hi  (r_hi),
        .o_mask   (w_mask),
        .o_wshift (w_wshift),
        .o_load   (w_load),
        .o_cross  (w_cross)
    );

    // Second word address wraps naturally at the top of the address space
    assign w_word0 = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_word1 = {r_addr[ADDR_W-1:2] + c_word_inc, 2'b00};

    assign w_bad_req = lsu_illegal(req_we_i, req_funct3_i) ||
                       ((MISALIGN_EN == 0) && lsu_crosses(req_addr_i[1:0], req_funct3_i));

    // Outputs are gated by rst so a reset arriving mid-access suppresses the
    // pending second write and any response in that same cycle.
    assign req_ready_o = !rst && (r_state == LSU_IDLE);
    assign rsp_valid_o = !rst && (r_state == LSU_DONE);
    assign rsp_err_o   = rsp_valid_o && r_err;
    assign rsp_rdata_o = (rsp_valid_o && !r_we && !r_err) ? w_load : '0;

    always_comb begin
        ram_addr_o    = '0;
        ram_wr_data_o = '0;
        ram_wr_en_o   = 1'b0;
        w_lane_mask   = 4'b0000;
        w_lane_new    = '0;
        if (!rst) begin
            case (r_state)
                LSU_ACC0: begin
                    ram_addr_o  = w_word0;
                    w_lane_mask = w_mask[3:0];
                    w_lane_new  = w_wshift[31:0];
                    ram_wr_en_o = r_we;
                end
                LSU_ACC1: begin
                    ram_addr_o  = w_word1;
                    w_lane_mask = w_mask[7:4];
                    w_lane_new  = w_wshift[63:32];
                    ram_wr_en_o = r_we;
                end
                default: ;
            endcase
        end
        // Bytewise merge of new lanes over the current RAM word
        for (int i = 0; i < 4; i++) begin
            ram_wr_data_o[8*i +: 8] = w_lane_mask[i] ? w_lane_new[8*i +: 8]
                                                     : ram_rd_data_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LSU_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        r_we     <= req_we_i;
                        r_funct3 <= req_funct3_i;
                        r_addr   <= req_addr_i;
                        r_wdata  <= req_wdata_i;
                        r_lo     <= '0;
                        r_hi     <= '0;
                        r_err    <= w_bad_req;
                        r_state  <= w_bad_req ? LSU_DONE : LSU_ACC0;
                    end
                end
                LSU_ACC0: begin
                    if (!r_we)
                        r_lo <= ram_rd_data_i;
                    r_state <= w_cross ? LSU_ACC1 : LSU_DONE;
                end
                LSU_ACC1: begin
                    if (!r_we)
                        r_hi <= ram_rd_data_i;
                    r_state <= LSU_DONE;
                end
                LSU_DONE: begin
                    r_state <= LSU_IDLE;
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed self-checking bench for lsu_ctrl. Instance A uses the
//            splitting configuration with a 16-word RAM model; instance B is
//            built with MISALIGN_EN=0 and a RAM that reads zero.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        rdy_a, rv_a, err_a, wen_a;
    logic [31:0] rdata_a, raddr_a, wdat_a, rrd_a;
    logic        rdy_b, rv_b, err_b, wen_b;
    logic [31:0] rdata_b, raddr_b, wdat_b;
    logic [31:0] rrd_b = 32'd0;

    logic [31:0] mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_data = 32'd0;
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;
    int          rv_cnt_a = 0;
    logic [31:0] wr_addr_last = 32'd0;
    logic [31:0] wr_addr_prev = 32'd0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .MISALIGN_EN(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid_i(valid_a), .req_ready_o(rdy_a), .req_we_i(req_we),
        .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv_a), .rsp_rdata_o(rdata_a), .rsp_err_o(err_a),
        .ram_addr_o(raddr_a), .ram_wr_data_o(wdat_a), .ram_wr_en_o(wen_a),
        .ram_rd_data_i(rrd_a)
    );

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .MISALIGN_EN(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid_i(valid_b), .req_ready_o(rdy_b), .req_we_i(req_we),
        .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv_b), .rsp_rdata_o(rdata_b), .rsp_err_o(err_b),
        .ram_addr_o(raddr_b), .ram_wr_data_o(wdat_b), .ram_wr_en_o(wen_b),
        .ram_rd_data_i(rrd_b)
    );

    // RAM model: combinational read, posedge write, word index from addr[5:2]
    assign rrd_a = mem[raddr_a[5:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (wen_a) begin
            mem[raddr_a[5:2]] <= wdat_a;
            wr_cnt_a     <= wr_cnt_a + 1;
            wr_addr_prev <= wr_addr_last;
            wr_addr_last <= raddr_a;
        end
        if (wen_b)
            wr_cnt_b <= wr_cnt_b + 1;
        if (rv_a)
            rv_cnt_a <= rv_cnt_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Issues one request, returns response data/err and the number of edges
    // from the accept edge until rsp_valid is visible. Leaves the DUT in IDLE.
    task automatic do_req(input bit sel, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int  n;
        bit  seen;
        n = 0;
        while (!(sel ? rdy_b : rdy_a) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req_we    = we;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wdata;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        seen  = 1'b0;
        lat   = 0;
        rdata = 32'd0;
        err   = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            if (sel ? rv_b : rv_a) begin
                seen  = 1'b1;
                lat   = k;
                rdata = sel ? rdata_b : rdata_a;
                err   = sel ? err_b : err_a;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("rsp_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wc0;
        int          rv0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'd0, rdy_a}, 32'd0);
        check("rst_rvalid", {31'd0, rv_a},  32'd0);
        check("rst_rdata",  rdata_a,        32'd0);
        check("rst_err",    {31'd0, err_a}, 32'd0);
        check("rst_wen",    {31'd0, wen_a}, 32'd0);
        check("rst_addr",   raddr_a,        32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, rdy_a}, 32'd1);
        preload(4'd4, 32'h0);

        // 1: aligned SW then LW
        wc0 = wr_cnt_a;
        do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("t1_sw_word4", mem[4], 32'hDEADBEEF);
        check("t1_sw_writes", 32'(wr_cnt_a - wc0), 32'd1);
        check("t1_sw_lat", 32'(lat), 32'd2);
        check("t1_sw_rdata", rd, 32'd0);
        wc0 = wr_cnt_a;
        do_req(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        check("t1_lw_rdata", rd, 32'hDEADBEEF);
        check("t1_lw_err", {31'd0, er}, 32'd0);
        check("t1_lw_lat", 32'(lat), 32'd2);
        check("t1_lw_nowrite", 32'(wr_cnt_a - wc0), 32'd0);

        // 2: SB read-modify-write, LB/LBU extension
        preload(4'd4, 32'h11223344);
        do_req(1'b0, 1'b1, 3'd0, 32'h11, 32'h000000AA, rd, er, lat);
        check("t2_sb_word4", mem[4], 32'h1122AA44);
        do_req(1'b0, 1'b0, 3'd0, 32'h11, 32'h0, rd, er, lat);
        check("t2_lb", rd, 32'hFFFFFFAA);
        do_req(1'b0, 1'b0, 3'd4, 32'h11, 32'h0, rd, er, lat);
        check("t2_lbu", rd, 32'h000000AA);
        do_req(1'b0, 1'b0, 3'd5, 32'h12, 32'h0, rd, er, lat);
        check("t2_lhu", rd, 32'h00001122);

        // 3: crossing SW/LW/LH
        preload(4'd4, 32'h0);
        preload(4'd5, 32'h0);
        do_req(1'b0, 1'b1, 3'd2, 32'h13, 32'hA1B2C3D4, rd, er, lat);
        check("t3_sw_word4", mem[4], 32'hD4000000);
        check("t3_sw_word5", mem[5], 32'h00A1B2C3);
        check("t3_sw_lat", 32'(lat), 32'd3);
        do_req(1'b0, 1'b0, 3'd2, 32'h13, 32'h0, rd, er, lat);
        check("t3_lw_rdata", rd, 32'hA1B2C3D4);
        check("t3_lw_lat", 32'(lat), 32'd3);
        do_req(1'b0, 1'b0, 3'd1, 32'h13, 32'h0, rd, er, lat);
        check("t3_lh_rdata", rd, 32'hFFFFC3D4);

        // 4: MISALIGN_EN=0 instance, plus illegal funct3
        do_req(1'b1, 1'b1, 3'd1, 32'h03, 32'h0000BEEF, rd, er, lat);
        check("t4_sh_err", {31'd0, er}, 32'd1);
        check("t4_sh_lat", 32'(lat), 32'd1);
        check("t4_sh_nowrite", 32'(wr_cnt_b), 32'd0);
        do_req(1'b1, 1'b0, 3'd7, 32'h00, 32'h0, rd, er, lat);
        check("t4_f7_err", {31'd0, er}, 32'd1);
        check("t4_f7_rdata", rd, 32'd0);
        do_req(1'b0, 1'b1, 3'd3, 32'h10, 32'h12345678, rd, er, lat);
        check("t4_st_f3_err", {31'd0, er}, 32'd1);
        check("t4_st_f3_word4", mem[4], 32'hD4000000);

        // 5: wrap-around crossing store
        preload(4'd15, 32'h0);
        preload(4'd0, 32'h0);
        do_req(1'b0, 1'b1, 3'd2, 32'hFFFFFFFE, 32'hCAFEF00D, rd, er, lat);
        check("t5_addr_first", wr_addr_prev, 32'hFFFFFFFC);
        check("t5_addr_second", wr_addr_last, 32'h00000000);
        check("t5_word15", mem[15], 32'hF00D0000);
        check("t5_word0", mem[0], 32'h0000CAFE);

        // 6: reset in ACC1 of a crossing store
        preload(4'd0, 32'h11111111);
        preload(4'd1, 32'h22222222);
        rv0 = rv_cnt_a;
        req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h2; req_wdata = 32'h55667788;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_wen_in_rst", {31'd0, wen_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_ready", {31'd0, rdy_a}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_word0", mem[0], 32'h77881111);
        check("t6_word1", mem[1], 32'h22222222);
        check("t6_no_rsp", 32'(rv_cnt_a - rv0), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
